// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the dual-requester byte memory controller.
//   * RISC-V load/store func3 encodings
//   * controller state enumeration
//   * size_bytes : func3 -> number of byte cycles (1, 2 or 4)
//   * load_ext   : sign/zero extension of an assembled load word
//   * f3_illegal : func3 encodings the controller refuses
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [2:0] func3);
    logic [2:0] n;
    case (func3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] func3,
                                           input logic [31:0] raw);
    logic [31:0] r;
    case (func3)
      F3_B:    r = {{24{raw[7]}}, raw[7:0]};
      F3_H:    r = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   r = {24'h000000, raw[7:0]};
      F3_HU:   r = {16'h0000, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // 011 and 11x are never valid; unsigned variants make no sense for stores.
  function automatic logic f3_illegal(input logic [2:0] func3, input logic we);
    return (func3 == 3'b011) || (func3[2:1] == 2'b11) || (we && func3[2]);
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb -- two-way round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : arbitration allowed this cycle (controller idle)
//   req_i[1:0]   : per-port requests
//   gnt_o[1:0]   : one-hot combinational grant
// The pointer remembers which port won last; reset value "port 1 last"
// so port 0 wins the first contended cycle.
module dmem_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i && !rst_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = 1'b0;
    end else if (gnt_o[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- shares a byte-wide data memory between the core LSU (port 0)
// and the debug/DMA master (port 1). Each b/h/w access becomes 1/2/4
// consecutive byte cycles (little-endian); loads are reassembled and
// sign/zero extended according to func3.
//   req_i/we_i/addr_i/wdata_i/func3_i : per-port request fields (2 ports)
//   gnt_o      : combinational grant pulse, fields sampled that cycle
//   rvalid_o   : completion pulse to the owning port
//   rdata_o    : extended load data (0 for stores/errors), with rvalid_o
//   err_o      : completion is an error, with rvalid_o
//   mem_*      : byte memory interface, read data one cycle after mem_en_o
// Build option: define DMEM_MISALIGN_EN to allow misaligned h/w accesses
// (addresses wrap modulo 2^AW); otherwise they complete with err_o.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      req_i,
  input  logic [1:0]      we_i,
  input  logic [2*AW-1:0] addr_i,
  input  logic [63:0]     wdata_i,
  input  logic [5:0]      func3_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      rvalid_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output logic            mem_en_o,
  output logic            mem_wren_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [7:0]      mem_wdata_o,
  input  logic [7:0]      mem_rdata_i
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    func3_q, func3_d;
  logic [2:0]    n_q, n_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [1:0]    gnt;
  logic          sel;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_f3;
  logic          misaligned;
  logic [1:0]    last_idx;

  dmem_rr_arb u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q == ST_IDLE),
    .req_i (req_i),
    .gnt_o (gnt)
  );

  assign gnt_o     = gnt;
  assign sel       = gnt[1];
  assign req_we    = sel ? we_i[1]             : we_i[0];
  assign req_addr  = sel ? addr_i[2*AW-1:AW]   : addr_i[AW-1:0];
  assign req_wdata = sel ? wdata_i[63:32]      : wdata_i[31:0];
  assign req_f3    = sel ? func3_i[5:3]        : func3_i[2:0];
  // n is 1, 2 or 4; the 2-bit difference yields 0, 1 or 3.
  assign last_idx  = n_q[1:0] - 2'd1;

  always_comb begin
    misaligned = 1'b0;
`ifndef DMEM_MISALIGN_EN
    misaligned = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    n_d     = n_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = sel;
          we_d    = req_we;
          base_d  = req_addr;
          wdata_d = req_wdata;
          func3_d = req_f3;
          n_d     = size_bytes(req_f3);
          idx_d   = 2'd0;
          buf_d   = 32'h0;
          rdata_d = 32'h0;
          if (f3_illegal(req_f3, req_we) || misaligned) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        // Read data lags the address by one cycle, so byte idx-1 lands now.
        if (!we_q && (idx_q != 2'd0)) begin
          buf_d[{idx_q - 2'd1, 3'b000} +: 8] = mem_rdata_i;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == last_idx) begin
          state_d = we_q ? ST_RESP : ST_DRAIN;
          rdata_d = 32'h0;
        end
      end

      ST_DRAIN: begin
        buf_d[{last_idx, 3'b000} +: 8] = mem_rdata_i;
        rdata_d = load_ext(func3_q, buf_d);
        state_d = ST_RESP;
      end

      ST_RESP: begin
        // Clear so rdata_o/err_o read 0 outside the completion pulse.
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'h0;
      func3_q <= 3'b000;
      n_q     <= 3'd0;
      idx_q   <= 2'd0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory side is decoded from state so an asynchronous reset drops it at once.
  assign mem_en_o    = (state_q == ST_XFER);
  assign mem_wren_o  = (state_q == ST_XFER) && we_q;
  assign mem_addr_o  = (state_q == ST_XFER) ? (base_q + {{(AW-2){1'b0}}, idx_q}) : '0;
  assign mem_wdata_o = mem_wren_o ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;

  assign rvalid_o    = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- directed self-checking bench for dmem_ctrl with a
// behavioural byte memory (registered read) preloaded at 0x100..0x103.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [1:0]      req_v;
  logic [1:0]      we_v;
  logic [2*AW-1:0] addr_v;
  logic [63:0]     wdata_v;
  logic [5:0]      func3_v;
  logic [1:0]      gnt_o;
  logic [1:0]      rvalid_o;
  logic [31:0]     rdata_o;
  logic            err_o;
  logic            mem_en_o;
  logic            mem_wren_o;
  logic [AW-1:0]   mem_addr_o;
  logic [7:0]      mem_wdata_o;
  logic [7:0]      mem_rdata = 8'h00;

  logic [7:0] mem [0:4095];
  logic       load_mem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_v),
    .we_i        (we_v),
    .addr_i      (addr_v),
    .wdata_i     (wdata_v),
    .func3_i     (func3_v),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_en_o    (mem_en_o),
    .mem_wren_o  (mem_wren_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'h11;
      mem[12'h101] <= 8'h22;
      mem[12'h102] <= 8'h33;
      mem[12'h103] <= 8'h84;
    end else if (mem_en_o && mem_wren_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
    if (mem_en_o && !mem_wren_o) mem_rdata <= mem[mem_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [2:0] f3);
    we_v[p]              = we;
    addr_v[p*AW +: AW]   = a;
    wdata_v[p*32 +: 32]  = wd;
    func3_v[p*3 +: 3]    = f3;
  endtask

  // One access: request, expect immediate grant, track byte cycles and
  // addresses, then check completion latency, data and error flag.
  task automatic run_txn(input string tag, input int p, input logic we,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_n);
    int cyc;
    int k;
    bit got;
    logic [AW-1:0] ea;
    @(negedge clk);
    set_port(p, we, a, wd, f3);
    req_v[p] = 1'b1;
    #1;
    check_eq({tag, " gnt"}, {30'd0, gnt_o}, (p == 0) ? 32'd1 : 32'd2);
    cyc = 0;
    k   = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_v[p] = 1'b0;
      if (mem_en_o) begin
        ea = a + k[AW-1:0];
        check_eq({tag, " addr"}, {20'd0, mem_addr_o}, {20'd0, ea});
        k++;
      end
      if (rvalid_o[p]) got = 1'b1;
    end
    check_eq({tag, " rvalid seen"}, {31'd0, got}, 32'd1);
    check_eq({tag, " latency"}, cyc, exp_lat);
    check_eq({tag, " byte cycles"}, k, exp_n);
    check_eq({tag, " rdata"}, rdata_o, exp_rd);
    check_eq({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
    $display("txn %s: port %0d we %0b addr 0x%03h f3 %03b -> rdata 0x%08h err %0b lat %0d",
             tag, p, we, a, f3, rdata_o, err_o, cyc);
  endtask

  initial begin
    int grants;
    int last_g;
    int prev_port;
    int rv_cnt;
    logic [1:0] g;

    rst_i    = 1'b1;
    load_mem = 1'b1;
    req_v    = 2'b00;
    we_v     = 2'b00;
    addr_v   = '0;
    wdata_v  = '0;
    func3_v  = '0;
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    #1;
    check_eq("reset gnt",    {30'd0, gnt_o}, 32'd0);
    check_eq("reset rvalid", {30'd0, rvalid_o}, 32'd0);
    check_eq("reset mem_en", {31'd0, mem_en_o}, 32'd0);
    check_eq("reset rdata",  rdata_o, 32'd0);
    check_eq("reset err",    {31'd0, err_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Loads with every extension flavour
    run_txn("lw 100",  0, 1'b0, 12'h100, 32'h0, F3_W,  32'h84332211, 1'b0, 6, 4);
    run_txn("lh 102",  0, 1'b0, 12'h102, 32'h0, F3_H,  32'hFFFF8433, 1'b0, 4, 2);
    run_txn("lhu 102", 0, 1'b0, 12'h102, 32'h0, F3_HU, 32'h00008433, 1'b0, 4, 2);
    run_txn("lb 103",  1, 1'b0, 12'h103, 32'h0, F3_B,  32'hFFFFFF84, 1'b0, 3, 1);
    run_txn("lbu 103", 0, 1'b0, 12'h103, 32'h0, F3_BU, 32'h00000084, 1'b0, 3, 1);

    // Stores
    run_txn("sw 200", 1, 1'b1, 12'h200, 32'hDEADBEEF, F3_W, 32'h0, 1'b0, 5, 4);
    check_eq("mem 200", {24'd0, mem[12'h200]}, 32'hEF);
    check_eq("mem 201", {24'd0, mem[12'h201]}, 32'hBE);
    check_eq("mem 202", {24'd0, mem[12'h202]}, 32'hAD);
    check_eq("mem 203", {24'd0, mem[12'h203]}, 32'hDE);
    run_txn("sb 204", 1, 1'b1, 12'h204, 32'h12345678, F3_B, 32'h0, 1'b0, 2, 1);
    check_eq("mem 204", {24'd0, mem[12'h204]}, 32'h78);
    check_eq("mem 205", {24'd0, mem[12'h205]}, 32'h00);
    run_txn("lw 200", 0, 1'b0, 12'h200, 32'h0, F3_W, 32'hDEADBEEF, 1'b0, 6, 4);

    // Illegal encodings
    run_txn("f3 011", 0, 1'b0, 12'h100, 32'h0, 3'b011, 32'h0, 1'b1, 1, 0);
    run_txn("f3 110", 1, 1'b0, 12'h100, 32'h0, 3'b110, 32'h0, 1'b1, 1, 0);
    run_txn("st bu",  0, 1'b1, 12'h100, 32'h0, F3_BU,  32'h0, 1'b1, 1, 0);

    // Misalignment / wrap
`ifdef DMEM_MISALIGN_EN
    run_txn("lw 101", 0, 1'b0, 12'h101, 32'h0, F3_W, 32'h00843322, 1'b0, 6, 4);
    run_txn("sw FFE", 1, 1'b1, 12'hFFE, 32'h01020304, F3_W, 32'h0, 1'b0, 5, 4);
    check_eq("mem FFE", {24'd0, mem[12'hFFE]}, 32'h04);
    check_eq("mem FFF", {24'd0, mem[12'hFFF]}, 32'h03);
    check_eq("mem 000", {24'd0, mem[12'h000]}, 32'h02);
    check_eq("mem 001", {24'd0, mem[12'h001]}, 32'h01);
`else
    run_txn("lw 101", 0, 1'b0, 12'h101, 32'h0, F3_W, 32'h0, 1'b1, 1, 0);
    run_txn("lh 101", 1, 1'b0, 12'h101, 32'h0, F3_H, 32'h0, 1'b1, 1, 0);
    run_txn("sw FFE", 1, 1'b1, 12'hFFE, 32'h01020304, F3_W, 32'h0, 1'b1, 1, 0);
    check_eq("mem FFE", {24'd0, mem[12'hFFE]}, 32'h00);
`endif

    // Both ports hold requests from reset: grants must alternate 0,1,0,1
    @(negedge clk);
    rst_i = 1'b1;
    set_port(0, 1'b0, 12'h100, 32'h0, F3_B);
    set_port(1, 1'b0, 12'h101, 32'h0, F3_B);
    req_v = 2'b11;
    @(negedge clk);
    rst_i     = 1'b0;
    grants    = 0;
    last_g    = 0;
    prev_port = 1;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      g = gnt_o;
      if (g != 2'b00) begin
        check_eq("rr onehot", {31'd0, (g == 2'b01) || (g == 2'b10)}, 32'd1);
        check_eq("rr order", {31'd0, g[1]}, (grants % 2 == 0) ? 32'd0 : 32'd1);
        if (grants > 0) check_eq("rr spacing", c - last_g, 4);
        $display("grant %0d: port %0d at cycle %0d", grants, g[1], c);
        last_g    = c;
        prev_port = int'(g[1]);
        grants++;
      end
      @(negedge clk);
    end
    check_eq("rr grant count", grants, 4);
    check_eq("rr last port", prev_port, 1);
    req_v = 2'b00;
    repeat (6) @(negedge clk);

    // Reset during the third byte cycle of a word store
    set_port(1, 1'b1, 12'h300, 32'hA1B2C3D4, F3_W);
    req_v[1] = 1'b1;
    #1;
    check_eq("rst sw gnt", {30'd0, gnt_o}, 32'd2);
    @(negedge clk);
    req_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst 3rd xfer wren", {31'd0, mem_wren_o}, 32'd1);
    check_eq("rst 3rd xfer addr", {20'd0, mem_addr_o}, 32'h302);
    rst_i = 1'b1;
    #1;
    check_eq("rst wren drop", {31'd0, mem_wren_o}, 32'd0);
    check_eq("rst en drop", {31'd0, mem_en_o}, 32'd0);
    @(negedge clk);
    rst_i  = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid_o != 2'b00) rv_cnt++;
    end
    check_eq("rst no rvalid", rv_cnt, 0);
    check_eq("rst mem 300", {24'd0, mem[12'h300]}, 32'hD4);
    check_eq("rst mem 301", {24'd0, mem[12'h301]}, 32'hC3);
    check_eq("rst mem 302", {24'd0, mem[12'h302]}, 32'h00);
    run_txn("post-rst lw", 0, 1'b0, 12'h100, 32'h0, F3_W, 32'h84332211, 1'b0, 6, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
